mix_uart_tx: RTL and testbench
==============================

Name: mix_uart_tx

Overview:
- Transmit-direction console device for the MIX core: on `start`, reads a block of MIX words from core memory through a request/grant port.
- Converts each word's five 6-bit MIX character codes to ASCII and sends them 8N1 on the UART `tx` line, followed by CR LF.
- Complements the receive-direction console device that fills memory from `rx`.
- Pulses `stop` when the block has been fully shifted out, so the top can resume fetch.

Parameters:
- DIVISOR, 217, clocks per UART bit (25 MHz / 115200).
- BLOCK, 14, words per block (terminal unit 19 block size).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin block transfer at `addressin`
- addressin  in  12  first memory address of the block
- request  out  1  word-read request to memory arbiter
- grant  in  1  arbiter accepts request; `addressout` is applied to memory this cycle
- addressout  out  12  memory address of the current word
- in  in  30  memory read data; valid exactly one cycle after the grant cycle
- busy  out  1  high from `start` acceptance until the `stop` pulse inclusive
- stop  out  1  one-cycle pulse after the last stop bit of LF
- tx  out  1  UART line; idle high

Behaviour:
- Reset values (async, while reset=0): tx=1, request=0, busy=0, stop=0, addressout=0.
- All FSM and counters clear on reset. A reset mid-frame forces tx=1 immediately; no partial byte completes.
- FSM states and transitions:
  - IDLE: on start, latch addressout=addressin, word count=0, busy=1, go to REQ. Start is ignored in every other state.
  - REQ: request=1 until grant sampled high. A grant held low for N cycles stalls N cycles with no timeout. On grant: request=0, go to LATCH.
  - LATCH: one cycle. Capture `in` into the word register, char index=0, go to CHAR.
  - CHAR: send char index 0..4, taken from word bits 29:24, 23:18, 17:12, 11:6, 5:0 in that order. After index 4:
    - if word count = BLOCK-1, go to EOL;
    - else addressout+1 (12-bit wrap 4095→0), word count+1, go to REQ.
  - EOL: send 0x0D then 0x0A, go to DONE.
  - DONE: stop=1 for one cycle, busy drops, go to IDLE. A start in this cycle is ignored.
- Character map (MIX code → ASCII):
  - 0 → space
  - 1–9 → A–I
  - 10 → '^' (Δ)
  - 11–19 → J–R
  - 20 → '[' (Σ)
  - 21 → ']' (Π)
  - 22–29 → S–Z
  - 30–39 → '0'–'9'
  - 40–55 → . , ( ) + - * / = $ < > @ ; : '
  - 56–63 → '?'
- UART framing:
  - 10-bit frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly DIVISOR clocks.
  - Successive bytes are back-to-back: the next start bit begins the clock after the previous stop bit ends.
  - The bit counter and baud counter are separate from the FSM. The FSM waits on a "byte done" strobe.
- Latency:
  - start → request high: 1 cycle.
  - grant → first start bit on tx: 2 cycles.
- Word fetching: the next word is not requested until the current word's 5th byte is finished. At most one outstanding request at any time.

Test Plan:
- BLOCK=1, DIVISOR=4, word at 100 = codes 08 05 13 13 16 ("HELLO"), start with addressin=100, grant tied 1 → request for addressout=100. tx carries bytes 0x48 0x45 0x4C 0x4C 0x4F 0x0D 0x0A, each bit 4 clocks, frames back-to-back. stop pulses once after 70 bit-times. busy falls with stop.
- BLOCK=3, words at 4094, 4095, 0 → addressout sequence 4094, 4095, 0. 15 data bytes plus CR LF.
- Grant held low 50 cycles in REQ → request stays high 50 cycles; tx idle high; no data byte lost or duplicated.
- Codes 0, 10, 20, 21, 63 in one word → bytes 0x20 0x5E 0x5B 0x5D 0x3F.
- Second start pulse during CHAR → ignored; exactly one stop pulse; byte count unchanged.
- Reset asserted mid start bit of the 3rd byte → tx=1, busy=0, request=0 in the same cycle. A new start after release sends a clean full block.

Source files
------------

// File: rtl/mix_uart_tx_if.sv
// Memory read port of the MIX console transmitter: a request/grant handshake,
// with read data returned one cycle after the grant.
interface mix_uart_tx_if;
  logic        request;
  logic        grant;
  logic [11:0] addressout;
  logic [29:0] in;

  modport master (output request, output addressout, input grant, input in);
  modport slave  (input request, input addressout, output grant, output in);
endinterface

// File: rtl/mix_uart_tx.sv
// MIX console transmitter: fetches a block of MIX words, converts each 6-bit
// character code to ASCII and shifts it out 8N1, then appends CR LF.
module mix_uart_tx #(
  parameter int DIVISOR = 217,
  parameter int BLOCK   = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [11:0]          addressin,
  mix_uart_tx_if.master        mem,
  output logic                 busy,
  output logic                 stop,
  output logic                 tx
);
  localparam int BW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int WW = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(BLOCK - 1);

  typedef enum logic [2:0] {IDLE, REQ, LATCH, CHAR, EOL, DONE} state_e;

  state_e        state_q, state_d;
  logic [11:0]   addr_q, addr_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [29:0]   word_q, word_d;
  logic [2:0]    idx_q, idx_d;
  logic          sent_q, sent_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          stop_q, stop_d;

  logic          act_q, act_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [8:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  logic          go;
  logic [7:0]    go_byte;
  logic          byte_done;

  function automatic logic [5:0] code_at(input logic [29:0] w, input logic [2:0] n);
    logic [5:0] c;
    case (n)
      3'd0:    c = w[29:24];
      3'd1:    c = w[23:18];
      3'd2:    c = w[17:12];
      3'd3:    c = w[11:6];
      default: c = w[5:0];
    endcase
    return c;
  endfunction

  // Letters run in three contiguous ASCII stretches broken by the Greek codes 10, 20, 21.
  function automatic logic [7:0] mix2ascii(input logic [5:0] c);
    logic [7:0] r;
    logic [7:0] c8;
    c8 = {2'b00, c};
    if (c == 6'd0)       r = 8'h20;
    else if (c <= 6'd9)  r = 8'h40 + c8;
    else if (c == 6'd10) r = 8'h5E;
    else if (c <= 6'd19) r = 8'h3F + c8;
    else if (c == 6'd20) r = 8'h5B;
    else if (c == 6'd21) r = 8'h5D;
    else if (c <= 6'd29) r = 8'h3D + c8;
    else if (c <= 6'd39) r = 8'h12 + c8;
    else begin
      case (c)
        6'd40: r = 8'h2E;  6'd41: r = 8'h2C;  6'd42: r = 8'h28;  6'd43: r = 8'h29;
        6'd44: r = 8'h2B;  6'd45: r = 8'h2D;  6'd46: r = 8'h2A;  6'd47: r = 8'h2F;
        6'd48: r = 8'h3D;  6'd49: r = 8'h24;  6'd50: r = 8'h3C;  6'd51: r = 8'h3E;
        6'd52: r = 8'h40;  6'd53: r = 8'h3B;  6'd54: r = 8'h3A;  6'd55: r = 8'h27;
        default: r = 8'h3F;
      endcase
    end
    return r;
  endfunction

  assign byte_done = act_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);

  // Sequencer: launches the next byte on the same edge the previous one finishes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    req_d   = req_q;
    busy_d  = busy_q;
    stop_d  = stop_q;
    go      = 1'b0;
    go_byte = 8'h00;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = addressin;
        wcnt_d  = '0;
        busy_d  = 1'b1;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (mem.grant) begin
        req_d   = 1'b0;
        state_d = LATCH;
      end
      LATCH: begin
        word_d  = mem.in;
        idx_d   = 3'd0;
        sent_d  = 1'b0;
        state_d = CHAR;
      end
      CHAR: begin
        if (!sent_q) begin
          go      = 1'b1;
          go_byte = mix2ascii(code_at(word_q, idx_q));
          sent_d  = 1'b1;
        end else if (byte_done) begin
          if (idx_q != 3'd4) begin
            idx_d   = idx_q + 3'd1;
            go      = 1'b1;
            go_byte = mix2ascii(code_at(word_q, idx_q + 3'd1));
          end else if (wcnt_q == WORD_LAST) begin
            idx_d   = 3'd0;
            go      = 1'b1;
            go_byte = 8'h0D;
            state_d = EOL;
          end else begin
            addr_d  = addr_q + 12'd1;
            wcnt_d  = wcnt_q + WW'(1);
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      EOL: if (byte_done) begin
        if (idx_q == 3'd0) begin
          idx_d   = 3'd1;
          go      = 1'b1;
          go_byte = 8'h0A;
        end else begin
          stop_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        stop_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit engine: sh holds the 8 data bits plus stop bit still to be driven.
  always_comb begin
    act_d  = act_q;
    bit_d  = bit_q;
    baud_d = baud_q;
    sh_d   = sh_q;
    tx_d   = tx_q;
    if (go) begin
      act_d  = 1'b1;
      bit_d  = 4'd0;
      baud_d = '0;
      sh_d   = {1'b1, go_byte};
      tx_d   = 1'b0;
    end else if (act_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          act_d = 1'b0;
          tx_d  = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      sent_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      act_q   <= 1'b0;
      bit_q   <= '0;
      baud_q  <= '0;
      sh_q    <= '1;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      act_q   <= act_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign mem.request    = req_q;
  assign mem.addressout = addr_q;
  assign busy           = busy_q;
  assign stop           = stop_q;
  assign tx             = tx_q;
endmodule

// File: tb/tb_mix_uart_tx.sv
// Directed bench for mix_uart_tx: a BLOCK=1 and a BLOCK=3 instance (DIVISOR=4),
// with per-line UART decoders and a one-cycle-latency memory model.
module tb_mix_uart_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, start3;
  logic [11:0] ain1, ain3;
  logic        gnt1, gnt3;
  logic        busy1, busy3, stop1, stop3, tx1, tx3;
  logic [29:0] rd1, rd3;
  logic [29:0] mem1 [0:4095];
  logic [29:0] mem3 [0:4095];

  mix_uart_tx_if b1 ();
  mix_uart_tx_if b3 ();

  mix_uart_tx #(.DIVISOR(4), .BLOCK(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .addressin(ain1),
    .mem(b1.master), .busy(busy1), .stop(stop1), .tx(tx1));
  mix_uart_tx #(.DIVISOR(4), .BLOCK(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .addressin(ain3),
    .mem(b3.master), .busy(busy3), .stop(stop3), .tx(tx3));

  assign b1.grant = gnt1;
  assign b3.grant = gnt3;
  assign b1.in    = rd1;
  assign b3.in    = rd3;

  always @(posedge clk) begin
    if (b1.request && b1.grant) rd1 <= mem1[b1.addressout];
    if (b3.request && b3.grant) rd3 <= mem3[b3.addressout];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitors, sampled on the falling edge; index 0 = u_dut1, 1 = u_dut3.
  logic        txl [2];
  logic        gv  [2];
  logic        sv  [2];
  logic [11:0] av  [2];
  assign txl[0] = tx1;  assign txl[1] = tx3;
  assign gv[0]  = b1.request & b1.grant;  assign gv[1] = b3.request & b3.grant;
  assign sv[0]  = stop1; assign sv[1] = stop3;
  assign av[0]  = b1.addressout; assign av[1] = b3.addressout;

  bit          mact  [2];
  int          mcnt  [2];
  logic [9:0]  mbits [2];
  byte         rxb   [2][0:127];
  int          rxn   [2];
  int          st_cyc[2][0:127];
  int          nst   [2];
  int          ferr  [2];
  int          stop_n[2];
  int          stop_cyc[2];
  int          gnt_n [2];
  logic [11:0] gaddr [2][0:63];
  int          gcyc  [2][0:63];

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (!reset) begin
        mact[l] = 1'b0;
      end else begin
        if (!mact[l]) begin
          if (!txl[l]) begin
            mact[l] = 1'b1;
            mcnt[l] = 0;
            mbits[l] = '0;
            st_cyc[l][nst[l] & 127] = cyc;
            nst[l]++;
          end
        end else begin
          mcnt[l]++;
        end
        if (mact[l]) begin
          if (mcnt[l] % 4 == 0) mbits[l][mcnt[l] / 4] = txl[l];
          else if (txl[l] !== mbits[l][mcnt[l] / 4]) ferr[l]++;
          if (mcnt[l] == 39) begin
            if (mbits[l][0] !== 1'b0 || mbits[l][9] !== 1'b1) ferr[l]++;
            rxb[l][rxn[l] & 127] = mbits[l][8:1];
            rxn[l]++;
            mact[l] = 1'b0;
          end
        end
        if (gv[l]) begin
          gaddr[l][gnt_n[l] & 63] = av[l];
          gcyc[l][gnt_n[l] & 63]  = cyc;
          gnt_n[l]++;
        end
        if (sv[l]) begin
          stop_cyc[l] = cyc;
          stop_n[l]++;
        end
      end
    end
  end

  int  ntot = 0, npass = 0, nfail = 0;
  byte ex[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input int l, input int base, input string tag);
    chk({tag, "_nbytes"}, 32'(rxn[l] - base), 32'(ex.size()));
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, rxb[l][(base + i) & 127]}, {24'h0, ex[i]});
  endtask

  task automatic wait_stop(input int l, input int budget, input string tag);
    int k = 0;
    while (((l == 0) ? stop1 : stop3) !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'h0, (l == 0) ? stop1 : stop3}, 32'h1);
  endtask

  int b0, s0, g0, p0, bad, reqhi, txhi, k;

  initial begin
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0; ain1 = '0; ain3 = '0;
    gnt1 = 1'b1; gnt3 = 1'b1; rd1 = '0; rd3 = '0;
    for (int i = 0; i < 4096; i++) begin mem1[i] = '0; mem3[i] = '0; end
    mem1[100]  = {6'd8, 6'd5, 6'd13, 6'd13, 6'd16};     // HELLO
    mem1[200]  = {6'd30, 6'd39, 6'd40, 6'd55, 6'd56};   // 0 9 . ' ?
    mem1[300]  = {6'd11, 6'd19, 6'd22, 6'd29, 6'd9};    // J R S Z I
    mem3[4094] = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5};        // A B C D E
    mem3[4095] = {6'd30, 6'd31, 6'd32, 6'd33, 6'd34};   // 0 1 2 3 4
    mem3[0]    = {6'd0, 6'd10, 6'd20, 6'd21, 6'd63};    // sp ^ [ ] ?

    repeat (3) tick();
    chk("rst_tx1",   {31'h0, tx1}, 32'h1);
    chk("rst_req1",  {31'h0, b1.request}, 32'h0);
    chk("rst_busy1", {31'h0, busy1}, 32'h0);
    chk("rst_stop1", {31'h0, stop1}, 32'h0);
    chk("rst_addr1", {20'h0, b1.addressout}, 32'h0);
    chk("rst_tx3",   {31'h0, tx3}, 32'h1);
    chk("rst_req3",  {31'h0, b3.request}, 32'h0);
    reset = 1'b1;
    repeat (2) tick();

    // HELLO, grant tied high
    b0 = rxn[0]; s0 = nst[0]; g0 = gnt_n[0]; p0 = stop_n[0];
    ain1 = 12'd100; start1 = 1'b1; tick(); start1 = 1'b0;
    chk("A_req_lat", {31'h0, b1.request}, 32'h1);
    chk("A_busy",    {31'h0, busy1}, 32'h1);
    chk("A_addr",    {20'h0, b1.addressout}, 32'd100);
    wait_stop(0, 2000, "A_stop");
    chk("A_busy_at_stop", {31'h0, busy1}, 32'h1);
    tick();
    chk("A_busy_after", {31'h0, busy1}, 32'h0);
    chk("A_stop_pulse", {31'h0, stop1}, 32'h0);
    ex = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
    chk_rx(0, b0, "A");
    chk("A_ngrant", 32'(gnt_n[0] - g0), 32'd1);
    chk("A_gaddr", {20'h0, gaddr[0][g0 & 63]}, 32'd100);
    // grant seen in the cycle before edge P; first start bit launched at edge P+2
    chk("A_grant_to_tx", 32'(st_cyc[0][s0 & 127] - gcyc[0][g0 & 63]), 32'd3);
    chk("A_stop_time", 32'(stop_cyc[0] - st_cyc[0][s0 & 127]), 32'd280);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (st_cyc[0][(s0 + i + 1) & 127] - st_cyc[0][(s0 + i) & 127] != 40) bad++;
    chk("A_b2b", 32'(bad), 32'd0);
    chk("A_nstop", 32'(stop_n[0] - p0), 32'd1);

    // Three words across the 12-bit address wrap
    b0 = rxn[1]; g0 = gnt_n[1]; p0 = stop_n[1];
    ain3 = 12'd4094; start3 = 1'b1; tick(); start3 = 1'b0;
    wait_stop(1, 4000, "B_stop");
    tick();
    ex = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
           8'h20, 8'h5E, 8'h5B, 8'h5D, 8'h3F, 8'h0D, 8'h0A};
    chk_rx(1, b0, "B");
    chk("B_ngrant", 32'(gnt_n[1] - g0), 32'd3);
    chk("B_gaddr0", {20'h0, gaddr[1][g0 & 63]}, 32'd4094);
    chk("B_gaddr1", {20'h0, gaddr[1][(g0 + 1) & 63]}, 32'd4095);
    chk("B_gaddr2", {20'h0, gaddr[1][(g0 + 2) & 63]}, 32'd0);
    chk("B_nstop", 32'(stop_n[1] - p0), 32'd1);

    // Grant withheld for 50 cycles
    b0 = rxn[0]; g0 = gnt_n[0];
    gnt1 = 1'b0; ain1 = 12'd200; start1 = 1'b1; tick(); start1 = 1'b0;
    reqhi = 0; txhi = 0;
    for (int i = 0; i < 50; i++) begin
      if (b1.request === 1'b1) reqhi++;
      if (tx1 === 1'b1) txhi++;
      tick();
    end
    gnt1 = 1'b1;
    chk("C_req_held", 32'(reqhi), 32'd50);
    chk("C_tx_idle", 32'(txhi), 32'd50);
    wait_stop(0, 2000, "C_stop");
    tick();
    ex = '{8'h30, 8'h39, 8'h2E, 8'h27, 8'h3F, 8'h0D, 8'h0A};
    chk_rx(0, b0, "C");
    chk("C_ngrant", 32'(gnt_n[0] - g0), 32'd1);

    // Second start while characters are shifting
    b0 = rxn[0]; g0 = gnt_n[0]; p0 = stop_n[0];
    ain1 = 12'd300; start1 = 1'b1; tick(); start1 = 1'b0;
    k = 0;
    while (rxn[0] < b0 + 1 && k < 500) begin tick(); k++; end
    chk("D_in_char", {31'h0, busy1}, 32'h1);
    ain1 = 12'd100; start1 = 1'b1; tick(); start1 = 1'b0;
    wait_stop(0, 2000, "D_stop");
    repeat (60) tick();
    ex = '{8'h4A, 8'h52, 8'h53, 8'h5A, 8'h49, 8'h0D, 8'h0A};
    chk_rx(0, b0, "D");
    chk("D_nstop", 32'(stop_n[0] - p0), 32'd1);
    chk("D_ngrant", 32'(gnt_n[0] - g0), 32'd1);
    chk("D_idle", {31'h0, busy1}, 32'h0);

    // Reset during the start bit of the third byte, then a clean block
    s0 = nst[1];
    ain3 = 12'd4094; start3 = 1'b1; tick(); start3 = 1'b0;
    k = 0;
    while (nst[1] < s0 + 3 && k < 1000) begin tick(); k++; end
    chk("E_third_start", 32'(nst[1] - s0), 32'd3);
    chk("E_tx_low", {31'h0, tx3}, 32'h0);
    reset = 1'b0;
    #1;
    chk("E_rst_tx", {31'h0, tx3}, 32'h1);
    chk("E_rst_busy", {31'h0, busy3}, 32'h0);
    chk("E_rst_req", {31'h0, b3.request}, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("E_quiet", {31'h0, tx3}, 32'h1);
    b0 = rxn[1]; p0 = stop_n[1];
    ain3 = 12'd4094; start3 = 1'b1; tick(); start3 = 1'b0;
    wait_stop(1, 4000, "E_stop");
    tick();
    ex = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
           8'h20, 8'h5E, 8'h5B, 8'h5D, 8'h3F, 8'h0D, 8'h0A};
    chk_rx(1, b0, "E");
    chk("E_nstop", 32'(stop_n[1] - p0), 32'd1);
    chk("frame_err1", 32'(ferr[0]), 32'd0);
    chk("frame_err3", 32'(ferr[1]), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
